// File: rtl/program_fetch_pkg.sv
// Shared widths and defaults for the program fetch unit and its instruction buffer.
package program_fetch_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam logic [15:0] RESET_PC_DEF = 16'h0000;
    localparam int STEP_DEF = 4;
    localparam int DEPTH_DEF = 2;
    localparam int INSTR_W = 32;
    localparam int ENTRY_W_DEF = INSTR_W + ADDR_W_DEF;

    // Counter width able to hold the values 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/program_fetch_fifo.sv
// Small circular instruction buffer with synchronous clear and combinational head outputs.
module fetch_fifo
    import program_fetch_pkg::*;
#(
    parameter int WIDTH = ENTRY_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] entries [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign valid  = (count != '0);
    assign pop_ok = pop & valid;
    assign head   = entries[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // The issuer reserves a slot before fetching, so a push into a full buffer is a bug.
            assert (!(push && !pop_ok && count == CNT_W'(DEPTH)));
            if (push) begin
                entries[wr_ptr] <= push_data;
                wr_ptr          <= next_ptr(wr_ptr);
            end
            if (pop_ok) rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/program_fetch.sv
// Sequential program fetch with one outstanding memory read, credit-based issue and redirect flush.
module program_fetch
    import program_fetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter int                STEP     = STEP_DEF,
    parameter int                DEPTH    = DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [7:0]         mem_data0,
    input  logic [7:0]         mem_data1,
    input  logic [7:0]         mem_data2,
    input  logic [7:0]         mem_data3,
    input  logic               enable,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc
);

    localparam int ENTRY_W = INSTR_W + ADDR_W;
    localparam int CNT_W   = cnt_width(DEPTH);

    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  inflight_pc;
    logic               inflight;
    logic               pop;
    logic               push;
    logic               issue;
    logic [CNT_W-1:0]   count;
    logic [CNT_W:0]     committed;
    logic [ENTRY_W-1:0] head;

    // A redirect discards the buffer, so decode gets no handshake that cycle.
    assign pop  = instr_valid & instr_ready & ~redirect_valid;
    assign push = inflight & ~redirect_valid;

    // Slots already owned: buffered words not leaving this cycle plus the word on its way.
    assign committed = (CNT_W+1)'(count) + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
    assign issue     = enable & ~redirect_valid & (committed < (CNT_W+1)'(DEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc;
            inflight <= 1'b0;
        end else if (issue) begin
            pc          <= pc + ADDR_W'(STEP);
            inflight    <= 1'b1;
            inflight_pc <= pc;
        end else begin
            inflight <= 1'b0;
        end
    end

    assign mem_addr = pc;
    assign instr    = head[ENTRY_W-1:ADDR_W];
    assign instr_pc = head[ADDR_W-1:0];

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_valid),
        .push      (push),
        .pop       (pop),
        .push_data ({mem_data3, mem_data2, mem_data1, mem_data0, inflight_pc}),
        .head      (head),
        .valid     (instr_valid),
        .count     (count)
    );

endmodule

// File: tb/tb_program_fetch.sv
// Directed and randomized bench for program_fetch against a sequential-stream reference model.
module tb_program_fetch;
    import program_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data0, mem_data1, mem_data2, mem_data3;
    logic        enable;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [15:0] instr_pc;

    logic [7:0]  mem8 [0:65535];
    int          checks = 0;
    int          errors = 0;
    int          accepted = 0;
    int          snap;
    logic [15:0] exp_pc;
    logic [15:0] base;

    program_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .mem_addr       (mem_addr),
        .mem_data0      (mem_data0),
        .mem_data1      (mem_data1),
        .mem_data2      (mem_data2),
        .mem_data3      (mem_data3),
        .enable         (enable),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [15:0] a);
        logic [15:0] a1, a2, a3;
        a1 = a + 16'd1;
        a2 = a + 16'd2;
        a3 = a + 16'd3;
        return {mem8[a3], mem8[a2], mem8[a1], mem8[a]};
    endfunction

    // Registered memory: bytes for the address seen at an edge appear after that edge.
    always @(posedge clk) {mem_data3, mem_data2, mem_data1, mem_data0} <= word_at(mem_addr);

    task automatic set_word(input logic [15:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem8[a + 16'(i)] = w[8*i +: 8];
    endtask

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with this cycle's inputs applied; advances one full cycle.
    task automatic tick();
        if (rst && instr_valid && instr_ready && !redirect_valid) begin
            check("stream_pc", 48'(instr_pc), 48'(exp_pc));
            check("stream_data", 48'(instr), 48'(word_at(exp_pc)));
            exp_pc = exp_pc + 16'd4;
            accepted++;
        end
        if (rst && redirect_valid) exp_pc = redirect_pc;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem8[i] = 8'($urandom);
        set_word(16'h0000, 32'h11223344);
        set_word(16'h0004, 32'h55667788);
        set_word(16'h0008, 32'h99AABBCC);

        rst = 1'b0;
        enable = 1'b1;
        instr_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        exp_pc = 16'h0000;
        repeat (2) @(negedge clk);
        check("reset_valid", 48'(instr_valid), 48'(0));
        check("reset_instr", 48'(instr), 48'(0));
        check("reset_instr_pc", 48'(instr_pc), 48'(0));
        check("reset_mem_addr", 48'(mem_addr), 48'(RESET_PC_DEF));

        // Startup latency and first three words.
        rst = 1'b1;
        tick();
        check("lat_edge1_valid", 48'(instr_valid), 48'(0));
        tick();
        check("lat_edge2_valid", 48'(instr_valid), 48'(1));
        check("first_pc", 48'(instr_pc), 48'(16'h0000));
        check("first_instr", 48'(instr), 48'(32'h11223344));
        tick();
        check("second_pc", 48'(instr_pc), 48'(16'h0004));
        check("second_instr", 48'(instr), 48'(32'h55667788));
        tick();
        check("third_pc", 48'(instr_pc), 48'(16'h0008));
        check("third_instr", 48'(instr), 48'(32'h99AABBCC));

        // Backpressure: buffer fills, address freezes, head holds.
        instr_ready = 1'b0;
        tick();
        check("stall_addr_early", 48'(mem_addr), 48'(exp_pc + 16'd8));
        repeat (4) tick();
        check("stall_addr_late", 48'(mem_addr), 48'(exp_pc + 16'd8));
        check("stall_valid", 48'(instr_valid), 48'(1));
        check("stall_head_pc", 48'(instr_pc), 48'(exp_pc));
        check("stall_head_instr", 48'(instr), 48'(word_at(exp_pc)));
        instr_ready = 1'b1;
        repeat (4) tick();

        // Jump back to 0, then redirect to 0x0100 while 0x0008 is in flight and 0x0004 is buffered.
        redirect_valid = 1'b1;
        redirect_pc = 16'h0000;
        tick();
        redirect_valid = 1'b0;
        repeat (3) tick();
        check("pre_redir_head", 48'(instr_pc), 48'(16'h0004));
        redirect_valid = 1'b1;
        redirect_pc = 16'h0100;
        tick();
        redirect_valid = 1'b0;
        check("redir_gap0", 48'(instr_valid), 48'(0));
        tick();
        check("redir_gap1", 48'(instr_valid), 48'(0));
        tick();
        check("redir_first_valid", 48'(instr_valid), 48'(1));
        check("redir_first_pc", 48'(instr_pc), 48'(16'h0100));
        repeat (3) tick();

        // Address wrap at the top of memory.
        redirect_valid = 1'b1;
        redirect_pc = 16'hFFF8;
        tick();
        redirect_valid = 1'b0;
        repeat (2) tick();
        check("wrap_pc0", 48'(instr_pc), 48'(16'hFFF8));
        check("wrap_instr0", 48'(instr), 48'(word_at(16'hFFF8)));
        tick();
        check("wrap_pc1", 48'(instr_pc), 48'(16'hFFFC));
        check("wrap_instr1", 48'(instr), 48'(word_at(16'hFFFC)));
        tick();
        check("wrap_pc2", 48'(instr_pc), 48'(16'h0000));
        check("wrap_instr2", 48'(instr), 48'(word_at(16'h0000)));

        // Fetch disabled: only the buffered head and the in-flight word come out.
        base = exp_pc;
        snap = accepted;
        enable = 1'b0;
        repeat (4) tick();
        check("dis_mem_addr", 48'(mem_addr), 48'(base + 16'd8));
        check("dis_delivered", 48'(accepted - snap), 48'(2));
        check("dis_valid", 48'(instr_valid), 48'(0));
        enable = 1'b1;
        tick();
        check("en_gap", 48'(instr_valid), 48'(0));
        tick();
        check("en_resume_valid", 48'(instr_valid), 48'(1));
        check("en_resume_pc", 48'(instr_pc), 48'(base + 16'd8));

        // Random enable / backpressure / redirects against the stream model.
        snap = accepted;
        for (int n = 0; n < 400; n++) begin
            enable = ($urandom_range(0, 7) != 0);
            instr_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc = 16'($urandom);
            tick();
        end
        enable = 1'b1;
        instr_ready = 1'b1;
        redirect_valid = 1'b0;
        repeat (4) tick();
        check("rand_progress", 48'(accepted - snap > 50), 48'(1));

        // Asynchronous reset between edges.
        #2 rst = 1'b0;
        #1;
        check("areset_valid", 48'(instr_valid), 48'(0));
        check("areset_mem_addr", 48'(mem_addr), 48'(RESET_PC_DEF));
        @(negedge clk);
        check("areset_hold_valid", 48'(instr_valid), 48'(0));
        rst = 1'b1;
        exp_pc = RESET_PC_DEF;
        tick();
        check("restart_edge1_valid", 48'(instr_valid), 48'(0));
        tick();
        check("restart_valid", 48'(instr_valid), 48'(1));
        check("restart_pc", 48'(instr_pc), 48'(RESET_PC_DEF));
        check("restart_instr", 48'(instr), 48'(32'h11223344));
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
